// File: rtl/n1_pbus_pkg.sv
// Shared types and widths for the N1 program-bus target.
package n1_pbus_pkg;

    localparam int unsigned PbusAdrWidth = 16;
    localparam int unsigned PbusDatWidth = 16;
    localparam int unsigned PbusSelWidth = 2;

    typedef enum logic [1:0] {RspAck, RspErr, RspRty} rsp_kind_t;

    typedef enum logic [1:0] {StIdle, StActive, StDrain} tgt_state_t;

    // One response-pipeline slot; dead marks a response cancelled by a cyc abort.
    typedef struct packed {
        logic      valid;
        logic      dead;
        rsp_kind_t kind;
        logic      we;
    } rsp_stage_t;

endpackage

// File: rtl/n1_pbus_tgt_rsp_pipe.sv
// Fixed-latency response pipeline for n1_pbus_tgt: MemLat slots of {valid, dead, kind, we}
// plus a count of occupied slots.
module n1_pbus_tgt_rsp_pipe
    import n1_pbus_pkg::*;
#(
    parameter int unsigned MemLat = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load,
    input  rsp_kind_t load_kind,
    input  logic      load_we,
    input  logic      flush,
    output logic      out_valid,
    output rsp_kind_t out_kind,
    output logic      out_we,
    output logic [2:0] outst,
    output logic [2:0] outst_next
);

    rsp_stage_t stage_q [MemLat];
    logic [2:0] outst_q;
    logic       exit_valid;

    assign exit_valid = stage_q[MemLat-1].valid;
    assign out_valid  = exit_valid & ~stage_q[MemLat-1].dead;
    assign out_kind   = stage_q[MemLat-1].kind;
    assign out_we     = stage_q[MemLat-1].we;
    assign outst      = outst_q;
    assign outst_next = outst_q + {2'b00, load} - {2'b00, exit_valid};

    // Shift slots toward the exit; a flush keeps them moving but marks them dead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MemLat); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= '{valid: load, dead: 1'b0, kind: load_kind, we: load_we};
            for (int i = 1; i < int'(MemLat); i++) begin
                stage_q[i]      <= stage_q[i-1];
                stage_q[i].dead <= stage_q[i-1].dead | flush;
            end
        end
    end

    // Occupied-slot count: an accept and an exit in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_q <= 3'd0;
        end else begin
            outst_q <= outst_next;
        end
    end

endmodule

// File: rtl/n1_pbus_tgt.sv
// Wishbone pipelined target for the N1 program bus, driving a fixed-latency SRAM.
// Build option: define N1_PBUS_TGT_RTY_EN to answer busy-SRAM requests with RTY instead
// of stalling them.
module n1_pbus_tgt
    import n1_pbus_pkg::*;
#(
    parameter int unsigned AdrWidth = PbusAdrWidth,
    parameter int unsigned DatWidth = PbusDatWidth,
    parameter int unsigned MemSize  = 16384,
    parameter int unsigned MemLat   = 1
) (
    input  logic                    clk_i,
    input  logic                    async_rst_i,
    input  logic                    pbus_cyc_i,
    input  logic                    pbus_stb_i,
    input  logic                    pbus_we_i,
    input  logic [PbusSelWidth-1:0] pbus_sel_i,
    input  logic [AdrWidth-1:0]     pbus_adr_i,
    input  logic [DatWidth-1:0]     pbus_dat_i,
    output logic [DatWidth-1:0]     pbus_dat_o,
    output logic                    pbus_ack_o,
    output logic                    pbus_err_o,
    output logic                    pbus_rty_o,
    output logic                    pbus_stall_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [PbusSelWidth-1:0] mem_sel_o,
    output logic [AdrWidth-1:0]     mem_adr_o,
    output logic [DatWidth-1:0]     mem_wdat_o,
    input  logic [DatWidth-1:0]     mem_rdat_i,
    input  logic                    mem_busy_i,
    output logic [1:0]              prb_pbus_tgt_state_o,
    output logic [2:0]              prb_pbus_tgt_outst_o
);

    localparam logic [AdrWidth:0] MemLimit = (AdrWidth + 1)'(MemSize);

    tgt_state_t state_q, state_d;
    rsp_kind_t  req_kind, out_kind;
    logic       stall_raw, accept, issue, out_valid, out_we, rsp_live;
    logic [2:0] outst, outst_next;

`ifdef N1_PBUS_TGT_RTY_EN
    assign stall_raw = (state_q == StDrain);
`else
    assign stall_raw = (state_q == StDrain) | mem_busy_i;
`endif

    // Reset gating keeps every output quiet while reset is held, even combinational ones.
    assign pbus_stall_o = stall_raw & async_rst_i;
    assign accept       = pbus_cyc_i & pbus_stb_i & ~stall_raw & async_rst_i;

    // Classify the request presented this cycle.
    always_comb begin
        req_kind = RspAck;
        if ({1'b0, pbus_adr_i} >= MemLimit) begin
            req_kind = RspErr;
`ifdef N1_PBUS_TGT_RTY_EN
        end else if (mem_busy_i) begin
            req_kind = RspRty;
`endif
        end
    end

    assign issue      = accept & (req_kind == RspAck);
    assign mem_req_o  = issue;
    assign mem_we_o   = issue & pbus_we_i;
    assign mem_sel_o  = issue ? pbus_sel_i : '0;
    assign mem_adr_o  = issue ? pbus_adr_i : '0;
    assign mem_wdat_o = issue ? pbus_dat_i : '0;

    n1_pbus_tgt_rsp_pipe #(
        .MemLat(MemLat)
    ) u_rsp_pipe (
        .clk        (clk_i),
        .rst_n      (async_rst_i),
        .load       (accept),
        .load_kind  (req_kind),
        .load_we    (pbus_we_i),
        .flush      (~pbus_cyc_i),
        .out_valid  (out_valid),
        .out_kind   (out_kind),
        .out_we     (out_we),
        .outst      (outst),
        .outst_next (outst_next)
    );

    // Responses only reach the bus while the cycle is still open.
    assign rsp_live   = out_valid & pbus_cyc_i;
    assign pbus_ack_o = rsp_live & (out_kind == RspAck);
    assign pbus_err_o = rsp_live & (out_kind == RspErr);
`ifdef N1_PBUS_TGT_RTY_EN
    assign pbus_rty_o = rsp_live & (out_kind == RspRty);
`else
    assign pbus_rty_o = 1'b0;
`endif
    assign pbus_dat_o = (pbus_ack_o & ~out_we) ? mem_rdat_i : '0;

    assign prb_pbus_tgt_state_o = state_q;
    assign prb_pbus_tgt_outst_o = outst;

    // Bus-cycle FSM state register.
    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; decisions use the post-edge occupancy so DRAIN ends as the last slot leaves.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pbus_cyc_i) state_d = StActive;
            end
            StActive: begin
                if (!pbus_cyc_i) state_d = (outst_next != 3'd0) ? StDrain : StIdle;
            end
            StDrain: begin
                if (outst_next == 3'd0) state_d = pbus_cyc_i ? StActive : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_n1_pbus_tgt.sv
// Directed bench for n1_pbus_tgt: three instances (MemLat 1, 2, 3) share one stimulus bus.
module tb_n1_pbus_tgt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, busy = 1'b0;
    logic [1:0]  sel = 2'b11;
    logic [15:0] adr = '0, wdat = '0;

    logic [15:0] dat_o [3];
    logic [15:0] mem_adr [3];
    logic [15:0] mem_wdat [3];
    logic [15:0] rdat [3];
    logic [1:0]  mem_sel [3];
    logic [1:0]  state [3];
    logic [2:0]  outst [3];
    logic [2:0]  ack, err, rty, stall, mem_req, mem_we;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] fmem(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A00);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [15:0] adr_dl [4];

        n1_pbus_tgt #(
            .MemLat(g + 1)
        ) u_dut (
            .clk_i                (clk),
            .async_rst_i          (rst_n),
            .pbus_cyc_i           (cyc),
            .pbus_stb_i           (stb),
            .pbus_we_i            (we),
            .pbus_sel_i           (sel),
            .pbus_adr_i           (adr),
            .pbus_dat_i           (wdat),
            .pbus_dat_o           (dat_o[g]),
            .pbus_ack_o           (ack[g]),
            .pbus_err_o           (err[g]),
            .pbus_rty_o           (rty[g]),
            .pbus_stall_o         (stall[g]),
            .mem_req_o            (mem_req[g]),
            .mem_we_o             (mem_we[g]),
            .mem_sel_o            (mem_sel[g]),
            .mem_adr_o            (mem_adr[g]),
            .mem_wdat_o           (mem_wdat[g]),
            .mem_rdat_i           (rdat[g]),
            .mem_busy_i           (busy),
            .prb_pbus_tgt_state_o (state[g]),
            .prb_pbus_tgt_outst_o (outst[g])
        );

        // SRAM model: read data for the address presented g+1 cycles earlier.
        always @(posedge clk) begin
            adr_dl[0] <= mem_adr[g];
            for (int i = 1; i < 4; i++) adr_dl[i] <= adr_dl[i-1];
        end
        assign rdat[g] = fmem(adr_dl[g]);
    end

    task automatic set_bus(input logic c, input logic s, input logic w, input logic [15:0] a,
                           input logic [15:0] d);
        cyc = c; stb = s; we = w; adr = a; wdat = d;
    endtask

    task automatic idle(input int n);
        set_bus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        busy = 1'b0;
        sel = 2'b11;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_bus(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0);
        #1;
        for (int g = 0; g < 3; g++) begin
            total++;
            if ({ack[g], err[g], rty[g], stall[g], mem_req[g]} !== 5'b0) begin
                bad++;
                $display("FAIL reset_flags inst%0d got %b want 00000", g,
                         {ack[g], err[g], rty[g], stall[g], mem_req[g]});
            end
            total++;
            if (state[g] !== 2'd0 || outst[g] !== 3'd0 || dat_o[g] !== 16'h0) begin
                bad++;
                $display("FAIL reset_state inst%0d got st=%0d outst=%0d dat=%h want 0 0 0000",
                         g, state[g], outst[g], dat_o[g]);
            end
        end
        @(negedge clk);
        set_bus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_read_lat1();
        set_bus(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0);
        #1;
        total++;
        if (mem_req[0] !== 1'b1 || mem_adr[0] !== 16'h0010) begin
            bad++;
            $display("FAIL read1_memreq got req=%b adr=%h want 1 0010", mem_req[0], mem_adr[0]);
        end
        @(negedge clk);
        set_bus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        total++;
        if (ack[0] !== 1'b1 || dat_o[0] !== 16'hBEEF) begin
            bad++;
            $display("FAIL read1_ack got ack=%b dat=%h want 1 beef", ack[0], dat_o[0]);
        end
        total++;
        if (err[0] !== 1'b0 || rty[0] !== 1'b0) begin
            bad++;
            $display("FAIL read1_noerr got err=%b rty=%b want 0 0", err[0], rty[0]);
        end
        @(negedge clk);
        #1;
        total++;
        if (ack[0] !== 1'b0) begin
            bad++;
            $display("FAIL read1_single got ack=%b want 0", ack[0]);
        end
        idle(5);
    endtask

    task automatic test_back_to_back();
        logic        exp_ack;
        logic [15:0] exp_dat;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) set_bus(1'b1, 1'b1, 1'b0, 16'(i), 16'h0);
            else       set_bus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
            #1;
            if (i < 4) begin
                total++;
                if (stall[1] !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_stall cyc%0d got %b want 0", i, stall[1]);
                end
            end
            exp_ack = (i >= 2 && i < 6);
            total++;
            if (ack[1] !== exp_ack) begin
                bad++;
                $display("FAIL b2b_ack cyc%0d got %b want %b", i, ack[1], exp_ack);
            end
            if (exp_ack) begin
                exp_dat = 16'h5A00 + 16'(i - 2);
                total++;
                if (dat_o[1] !== exp_dat) begin
                    bad++;
                    $display("FAIL b2b_data cyc%0d got %h want %h", i, dat_o[1], exp_dat);
                end
            end
            if (i == 3) begin
                total++;
                if (outst[1] !== 3'd2) begin
                    bad++;
                    $display("FAIL b2b_outst got %0d want 2", outst[1]);
                end
            end
            @(negedge clk);
        end
        idle(5);
    endtask

    task automatic test_err_range();
        set_bus(1'b1, 1'b1, 1'b0, 16'h4000, 16'h0);
        #1;
        total++;
        if (mem_req !== 3'b000) begin
            bad++;
            $display("FAIL err_memreq got %b want 000", mem_req);
        end
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            set_bus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
            #1;
            if (i == 1) begin
                total++;
                if (err[0] !== 1'b1 || ack[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL err_lat1 got err=%b ack=%b want 1 0", err[0], ack[0]);
                end
            end
            total++;
            if (err[2] !== (i == 3)) begin
                bad++;
                $display("FAIL err_lat3 cyc%0d got %b want %b", i, err[2], (i == 3));
            end
        end
        idle(5);
    endtask

    task automatic test_busy();
`ifdef N1_PBUS_TGT_RTY_EN
        busy = 1'b1;
        set_bus(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0);
        #1;
        total++;
        if (stall[0] !== 1'b0 || mem_req[0] !== 1'b0) begin
            bad++;
            $display("FAIL rty_issue got stall=%b req=%b want 0 0", stall[0], mem_req[0]);
        end
        @(negedge clk);
        busy = 1'b0;
        set_bus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        total++;
        if (rty[0] !== 1'b1 || ack[0] !== 1'b0 || err[0] !== 1'b0) begin
            bad++;
            $display("FAIL rty_resp got rty=%b ack=%b err=%b want 1 0 0", rty[0], ack[0], err[0]);
        end
`else
        busy = 1'b1;
        set_bus(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0);
        #1;
        total++;
        if (stall[0] !== 1'b1 || mem_req[0] !== 1'b0) begin
            bad++;
            $display("FAIL busy_stall got stall=%b req=%b want 1 0", stall[0], mem_req[0]);
        end
        @(negedge clk);
        #1;
        total++;
        if (ack[0] !== 1'b0 || stall[0] !== 1'b1) begin
            bad++;
            $display("FAIL busy_hold got ack=%b stall=%b want 0 1", ack[0], stall[0]);
        end
        @(negedge clk);
        busy = 1'b0;
        #1;
        total++;
        if (stall[0] !== 1'b0 || mem_req[0] !== 1'b1) begin
            bad++;
            $display("FAIL busy_release got stall=%b req=%b want 0 1", stall[0], mem_req[0]);
        end
        @(negedge clk);
        set_bus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        total++;
        if (ack[0] !== 1'b1 || dat_o[0] !== 16'h5A05 || rty[0] !== 1'b0) begin
            bad++;
            $display("FAIL busy_ack got ack=%b dat=%h rty=%b want 1 5a05 0",
                     ack[0], dat_o[0], rty[0]);
        end
`endif
        idle(5);
    endtask

    task automatic test_write();
        sel = 2'b01;
        set_bus(1'b1, 1'b1, 1'b1, 16'h0020, 16'h1234);
        #1;
        total++;
        if (mem_we[0] !== 1'b1 || mem_wdat[0] !== 16'h1234 || mem_sel[0] !== 2'b01) begin
            bad++;
            $display("FAIL write_mem got we=%b wdat=%h sel=%b want 1 1234 01",
                     mem_we[0], mem_wdat[0], mem_sel[0]);
        end
        @(negedge clk);
        set_bus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        total++;
        if (ack[0] !== 1'b1 || dat_o[0] !== 16'h0) begin
            bad++;
            $display("FAIL write_ack got ack=%b dat=%h want 1 0000", ack[0], dat_o[0]);
        end
        idle(5);
    endtask

    task automatic test_abort();
        logic [1:0] exp_st;
        set_bus(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0);
        @(negedge clk);
        set_bus(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0);
        @(negedge clk);
        set_bus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        total++;
        if (state[2] !== 2'd1 || outst[2] !== 3'd2) begin
            bad++;
            $display("FAIL abort_start got st=%0d outst=%0d want 1 2", state[2], outst[2]);
        end
        for (int i = 3; i < 7; i++) begin
            @(negedge clk);
            #1;
            exp_st = (i < 5) ? 2'd2 : 2'd0;
            total++;
            if (state[2] !== exp_st) begin
                bad++;
                $display("FAIL abort_state cyc%0d got %0d want %0d", i, state[2], exp_st);
            end
            total++;
            if ({ack[2], err[2], rty[2]} !== 3'b000) begin
                bad++;
                $display("FAIL abort_silent cyc%0d got %b want 000", i, {ack[2], err[2], rty[2]});
            end
            if (i == 3) begin
                total++;
                if (stall[2] !== 1'b1) begin
                    bad++;
                    $display("FAIL abort_stall got %b want 1", stall[2]);
                end
            end
            if (i == 5) begin
                total++;
                if (outst[2] !== 3'd0) begin
                    bad++;
                    $display("FAIL abort_outst got %0d want 0", outst[2]);
                end
            end
        end
        idle(3);
    endtask

    task automatic test_reset_mid();
        set_bus(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0);
        @(negedge clk);
        set_bus(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0);
        @(negedge clk);
        set_bus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        rst_n = 1'b0;
        #1;
        total++;
        if (outst[2] !== 3'd0 || state[2] !== 2'd0) begin
            bad++;
            $display("FAIL rstmid_pipe got outst=%0d st=%0d want 0 0", outst[2], state[2]);
        end
        total++;
        if ({ack, err, rty, stall, mem_req} !== 15'b0) begin
            bad++;
            $display("FAIL rstmid_out got %b want all 0", {ack, err, rty, stall, mem_req});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 3; i < 8; i++) begin
            #1;
            total++;
            if ({ack, err, rty} !== 9'b0) begin
                bad++;
                $display("FAIL rstmid_late cyc%0d got %b want 0", i, {ack, err, rty});
            end
            @(negedge clk);
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_read_lat1();
        test_back_to_back();
        test_err_range();
        test_busy();
        test_write();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
